// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: widths, reset PC, fetch FSM encoding,
// major opcodes and the fetch buffer entry layout.
package riscv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned OPCODE_W = 7;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Major opcodes consumed by the control decoder
  localparam logic [OPCODE_W-1:0] OP_OP     = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

  // Fetch FSM: REQ may issue, WAIT has one request in flight,
  // DROP still has a request in flight whose response is stale.
  typedef logic [1:0] ifu_state_t;
  localparam ifu_state_t IFU_REQ  = 2'd0;
  localparam ifu_state_t IFU_WAIT = 2'd1;
  localparam ifu_state_t IFU_DROP = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/ifu_fifo2.sv
// Two-entry instruction buffer; the head entry always sits in the same
// register so the decoder sees flop outputs directly.
module ifu_fifo2
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  fetch_entry_t tail;
  logic         head_vld;
  logic         tail_vld;
  logic         pop_ok;

  assign pop_ok = pop & head_vld;

  // Shift organisation: pop moves tail into head, push fills the first free slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      head_vld <= 1'b0;
      tail_vld <= 1'b0;
    end else if (flush) begin
      head_vld <= 1'b0;
      tail_vld <= 1'b0;
    end else if (push && pop_ok) begin
      if (tail_vld) begin
        head <= tail;
        tail <= push_entry;
      end else begin
        head <= push_entry;
      end
    end else if (pop_ok) begin
      head     <= tail;
      head_vld <= tail_vld;
      tail_vld <= 1'b0;
    end else if (push) begin
      if (!head_vld) begin
        head     <= push_entry;
        head_vld <= 1'b1;
      end else if (!tail_vld) begin
        tail     <= push_entry;
        tail_vld <= 1'b1;
      end
    end
  end

  assign full  = tail_vld;
  assign empty = ~head_vld;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding imem requester feeding a
// 2-entry decode buffer. Define IFU_MISALIGN_CHECK_EN for misalign_err.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [XLEN-1:0]     imem_rdata,
  input  logic                redirect,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                if_valid,
  input  logic                if_ready,
  output logic [XLEN-1:0]     if_instr,
  output logic [OPCODE_W-1:0] if_opcode,
  output logic [XLEN-1:0]     if_pc
`ifdef IFU_MISALIGN_CHECK_EN
  ,
  output logic                misalign_err
`endif
);

  // Buffer depth is fixed at two entries; the parameter is kept for compatibility
  localparam int unsigned BUF_DEPTH_UNUSED = BUF_DEPTH;

  ifu_state_t      state;
  ifu_state_t      state_d;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc_d;
  logic [XLEN-1:0] imem_addr_d;
  logic [XLEN-1:0] target_pc;
  logic            imem_req_d;
  logic            redirect_go;
  logic            fetch_stop;
  logic            push;
  logic            pop;
  logic            flush;
  logic            buf_full;
  logic            buf_empty;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

`ifdef IFU_MISALIGN_CHECK_EN
  logic redirect_bad;
  logic misalign_d;

  // A misaligned redirect is dropped and permanently stops new fetches
  assign redirect_bad = redirect & (redirect_pc[1:0] != 2'b00);
  assign redirect_go  = redirect & ~redirect_bad;
  assign target_pc    = redirect_pc;
  assign fetch_stop   = misalign_err;
  assign misalign_d   = misalign_err | redirect_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= misalign_d;
    end
  end
`else
  logic redirect_pc_unused;

  assign redirect_pc_unused = ^redirect_pc[1:0];
  assign redirect_go        = redirect;
  assign target_pc          = {redirect_pc[XLEN-1:2], 2'b00};
  assign fetch_stop         = 1'b0;
`endif

  assign push_entry = '{pc: fetch_pc, instr: imem_rdata};
  assign pop        = if_valid & if_ready & ~redirect_go;

  // Next-state and registered-output logic; redirect overrides push/pop
  always_comb begin
    state_d     = state;
    fetch_pc_d  = fetch_pc;
    imem_req_d  = imem_req;
    imem_addr_d = imem_addr;
    push        = 1'b0;
    flush       = 1'b0;

    case (state)
      IFU_REQ: begin
        if (!redirect_go && !buf_full && !fetch_stop) begin
          imem_req_d  = 1'b1;
          imem_addr_d = fetch_pc;
          state_d     = IFU_WAIT;
        end
      end
      IFU_WAIT: begin
        if (imem_ack) begin
          imem_req_d = 1'b0;
          state_d    = IFU_REQ;
          if (!redirect_go) begin
            push       = 1'b1;
            fetch_pc_d = next_pc(fetch_pc);
          end
        end else if (redirect_go) begin
          state_d = IFU_DROP;
        end
      end
      IFU_DROP: begin
        if (imem_ack) begin
          imem_req_d = 1'b0;
          state_d    = IFU_REQ;
        end
      end
      default: begin
        imem_req_d = 1'b0;
        state_d    = IFU_REQ;
      end
    endcase

    if (redirect_go) begin
      flush      = 1'b1;
      fetch_pc_d = target_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IFU_REQ;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      state     <= state_d;
      fetch_pc  <= fetch_pc_d;
      imem_req  <= imem_req_d;
      imem_addr <= imem_addr_d;
    end
  end

  ifu_fifo2 u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .full       (buf_full),
    .empty      (buf_empty),
    .head       (head)
  );

  assign if_valid  = ~buf_empty;
  assign if_instr  = head.instr;
  assign if_pc     = head.pc;
  assign if_opcode = head.instr[OPCODE_W-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; the misalign scenario is built only
// when IFU_MISALIGN_CHECK_EN is defined.
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                imem_req;
  logic [XLEN-1:0]     imem_addr;
  logic                imem_ack;
  logic [XLEN-1:0]     imem_rdata;
  logic                redirect;
  logic [XLEN-1:0]     redirect_pc;
  logic                if_valid;
  logic                if_ready;
  logic [XLEN-1:0]     if_instr;
  logic [OPCODE_W-1:0] if_opcode;
  logic [XLEN-1:0]     if_pc;
`ifdef IFU_MISALIGN_CHECK_EN
  logic                misalign_err;
`endif
  logic                ack_en;

  int vectors     = 0;
  int miscompares = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .if_valid     (if_valid),
    .if_ready     (if_ready),
    .if_instr     (if_instr),
    .if_opcode    (if_opcode),
    .if_pc        (if_pc)
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    .misalign_err (misalign_err)
`endif
  );

  always #5 clk = ~clk;

  // Memory answers in the same cycle a request is visible, when enabled
  assign imem_ack = ack_en & imem_req;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!if_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_if_valid", 32'(if_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    ack_en      = 1'b0;
    if_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_rdata  = 32'h0000_0033;

    // Reset state
    @(negedge clk);
    check("rst_imem_req",  32'(imem_req),  32'd0);
    check("rst_imem_addr", imem_addr,      32'h0000_0000);
    check("rst_if_valid",  32'(if_valid),  32'd0);
    check("rst_if_instr",  if_instr,       32'h0000_0000);
    check("rst_if_opcode", 32'(if_opcode), 32'd0);
    check("rst_if_pc",     if_pc,          32'h0000_0000);
`ifdef IFU_MISALIGN_CHECK_EN
    check("rst_misalign",  32'(misalign_err), 32'd0);
`endif

    // Streaming with decoder always ready
    ack_en   = 1'b1;
    if_ready = 1'b1;
    rst      = 1'b0;
    @(negedge clk);
    check("first_req",      32'(imem_req), 32'd1);
    check("first_req_addr", imem_addr,     32'h0000_0000);
    for (int k = 0; k < 3; k++) begin
      wait_valid(8);
      check("stream_pc",     if_pc,          32'(4 * k));
      check("stream_opcode", 32'(if_opcode), 32'(OP_OP));
      check("stream_instr",  if_instr,       32'h0000_0033);
      @(negedge clk);
    end

    // Reset in the middle of a transaction
    check("midreset_pre_req", 32'(imem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("midreset_req",   32'(imem_req), 32'd0);
    check("midreset_addr",  imem_addr,     32'h0000_0000);
    check("midreset_valid", 32'(if_valid), 32'd0);
    if_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Decoder stalled: buffer fills to two, requests stop
    repeat (6) @(negedge clk);
    check("stall_req",   32'(imem_req), 32'd0);
    check("stall_valid", 32'(if_valid), 32'd1);
    check("stall_pc0",   if_pc,         32'h0000_0000);
    if_ready = 1'b1;
    @(negedge clk);
    check("release_valid1", 32'(if_valid), 32'd1);
    check("release_pc1",    if_pc,         32'h0000_0004);
    check("release_req1",   32'(imem_req), 32'd0);
    @(negedge clk);
    check("release_empty",  32'(if_valid), 32'd0);
    check("release_req2",   32'(imem_req), 32'd1);
    check("release_addr2",  imem_addr,     32'h0000_0008);

    // Redirect while waiting: stale response must be dropped
    ack_en      = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    @(negedge clk);
    redirect = 1'b0;
    check("drop_req_held",  32'(imem_req), 32'd1);
    check("drop_addr_held", imem_addr,     32'h0000_0008);
    check("drop_valid",     32'(if_valid), 32'd0);
    imem_rdata = 32'hBAD0_0063;
    ack_en     = 1'b1;
    @(negedge clk);
    check("drop_discard_valid", 32'(if_valid), 32'd0);
    check("drop_done_req",      32'(imem_req), 32'd0);
    imem_rdata = 32'h0000_0003;
    @(negedge clk);
    check("redir_req",  32'(imem_req), 32'd1);
    check("redir_addr", imem_addr,     32'h0000_0100);
    @(negedge clk);
    check("redir_valid",  32'(if_valid),  32'd1);
    check("redir_pc",     if_pc,          32'h0000_0100);
    check("redir_instr",  if_instr,       32'h0000_0003);
    check("redir_opcode", 32'(if_opcode), 32'(OP_LOAD));
    @(negedge clk);
    check("redir_no_dup", 32'(if_valid), 32'd0);
    check("redir_next",   imem_addr,     32'h0000_0104);

    // Redirect coinciding with ack and pop
    if_ready = 1'b0;
    @(negedge clk);
    check("coinc_head_pc", if_pc, 32'h0000_0104);
    @(negedge clk);
    check("coinc_req",  32'(imem_req), 32'd1);
    check("coinc_addr", imem_addr,     32'h0000_0108);
    if_ready    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    @(negedge clk);
    redirect = 1'b0;
    check("coinc_flushed", 32'(if_valid), 32'd0);
    check("coinc_req_low", 32'(imem_req), 32'd0);
    @(negedge clk);
    check("coinc_new_req",  32'(imem_req), 32'd1);
    check("coinc_new_addr", imem_addr,     32'h0000_0200);
    @(negedge clk);
    check("coinc_new_pc", if_pc, 32'h0000_0200);

    // Fetch address wraps past the top of the address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    check("wrap_flushed", 32'(if_valid), 32'd0);
    @(negedge clk);
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_pc_top", if_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_req",  32'(imem_req), 32'd1);
    check("wrap_addr", imem_addr,     32'h0000_0000);

`ifdef IFU_MISALIGN_CHECK_EN
    // Misaligned redirect is ignored, flags an error and halts fetch
    rst = 1'b1;
    #1;
    check("mis_rst_err", 32'(misalign_err), 32'd0);
    ack_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mis_req0", 32'(imem_req), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    @(negedge clk);
    redirect = 1'b0;
    check("mis_err_set", 32'(misalign_err), 32'd1);
    ack_en = 1'b1;
    repeat (3) @(negedge clk);
    check("mis_err_sticky", 32'(misalign_err), 32'd1);
    check("mis_req_off",    32'(imem_req),     32'd0);
    check("mis_addr",       imem_addr,         32'h0000_0000);
    rst = 1'b1;
    #1;
    check("mis_err_cleared", 32'(misalign_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
`else
    // Low redirect bits are forced to zero
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    @(negedge clk);
    redirect = 1'b0;
    check("align_flushed", 32'(if_valid), 32'd0);
    @(negedge clk);
    check("align_req",  32'(imem_req), 32'd1);
    check("align_addr", imem_addr,     32'h0000_0100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning instruction buffer entries (fixed at 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port imem_req, output, 1 bit: fetch request valid.
REQ-006 SHALL have port imem_addr, output, 32 bits: word-aligned fetch address.
REQ-007 SHALL have port imem_ack, input, 1 bit: response valid, carrying imem_rdata.
REQ-008 SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-009 SHALL have port redirect, input, 1 bit: taken branch or jump, one-cycle pulse.
REQ-010 SHALL have port redirect_pc, input, 32 bits: new fetch address.
REQ-011 SHALL have port if_valid, output, 1 bit: instruction available to the decoder.
REQ-012 SHALL have port if_ready, input, 1 bit: decoder accepts the instruction.
REQ-013 SHALL have port if_instr, output, 32 bits: instruction word.
REQ-014 SHALL have port if_opcode, output, 7 bits: if_instr[6:0], the opcode field I[6:0] that feeds the control decoder.
REQ-015 SHALL have port if_pc, output, 32 bits: address of if_instr.

Function
REQ-016 SHALL use FSM states REQ (request outstanding-free, may issue), WAIT (one request in flight) and DROP (in-flight response to be discarded).
REQ-017 SHALL allow at most one outstanding imem request.
REQ-018 SHALL hold imem_req and imem_addr stable from assertion until imem_ack.
REQ-019 SHALL assert imem_req in REQ only when buffer occupancy is below 2.
REQ-020 SHALL move REQ->WAIT on issue; on imem_ack in WAIT, SHALL push {fetch_pc, imem_rdata}, set fetch_pc += 4 (mod 2^32 wrap), and return to REQ.
REQ-021 SHALL allow imem_ack in the cycle after issue, giving a minimum 2-cycle latency from imem_req to if_valid.
REQ-022 SHALL present the buffer head on if_valid, if_instr and if_pc, and pop it when if_valid && if_ready.
REQ-023 SHALL support push and pop in the same cycle at occupancy 1 or 2 with no bubble.
REQ-024 SHALL, on redirect, flush the buffer (if_valid=0 next cycle) and load fetch_pc with redirect_pc.
REQ-025 SHALL, on redirect while in WAIT with no ack in that cycle, enter DROP.
REQ-026 SHALL discard the next imem_ack while in DROP, then enter REQ.
REQ-027 SHALL discard an ack that coincides with a redirect.
REQ-028 SHALL give redirect priority over push and pop in the same cycle.
REQ-029 SHALL not re-assert imem_req in DROP.

Reset
REQ-030 SHALL on rst set: state=REQ, fetch_pc=RESET_PC, buffer empty, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_opcode=0, if_pc=0, misalign_err=0.
REQ-031 SHALL abandon any in-flight request when reset is asserted mid-transaction; the memory side is reset concurrently.
REQ-032 SHALL raise the first imem_req in the first clock edge after rst deasserts.

Configuration
REQ-033 SHALL, when IFU_MISALIGN_CHECK_EN is defined, add output misalign_err (1 bit, sticky until rst) that is set when redirect_pc[1:0]!=0; the redirect is ignored and fetching stops with imem_req=0.
REQ-034 SHALL, when IFU_MISALIGN_CHECK_EN is undefined, omit the misalign_err port and force redirect_pc[1:0] to 2'b00.

Structure
REQ-035 SHALL place the XLEN=32 constant, the RESET_PC default, the FSM state typedef and the opcode constants (7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011) in shared package riscv_pkg.
REQ-036 SHALL implement the 2-entry buffer as sub-module ifu_fifo2 with push, pop, flush, full, empty, and a 64-bit {pc,instr} entry.

Verification
REQ-037 SHALL verify: reset release, RESET_PC=0, ack with 32'h0000_0033 one cycle after each request, if_ready=1 -> if_pc sequence 0,4,8 with if_opcode=7'b0110011.
REQ-038 SHALL verify: if_ready=0 for 6 cycles -> exactly 2 entries buffered, imem_req low while full, order preserved (0,4) on release.
REQ-039 SHALL verify: redirect to 32'h0000_0100 while in WAIT -> stale ack dropped, next if_pc=32'h100, no duplicate or stale instruction.
REQ-040 SHALL verify: redirect in the same cycle as imem_ack and pop -> buffer empty next cycle, next imem_addr=redirect_pc.
REQ-041 SHALL verify: fetch_pc=32'hFFFF_FFFC with ack -> following imem_addr=32'h0000_0000.
REQ-042 SHALL verify, with IFU_MISALIGN_CHECK_EN: redirect_pc=32'h0000_0102 -> misalign_err=1 stays high and imem_req=0; rst clears it.
